// File: rtl/aes128_dec_iter_pkg.sv
// Shared constants, state encoding and GF(2^8)/key-schedule helpers for the
// iterative AES-128 decryption core.
`ifndef L
`define L 16
`endif
`ifndef RED
`define RED 8'h1b
`endif

package aes128_dec_iter_pkg;

  localparam int         CNT_W      = 4;
  localparam logic [7:0] RCON_FIRST = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_KEXP = 2'd1,
    ST_DEC  = 2'd2,
    ST_DONE = 2'd3
  } fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? `RED : 8'h00);
  endfunction

  // Inverse of xtime on the Rcon sequence (0x1b -> 0x80).
  function automatic logic [7:0] rcon_inv(input logic [7:0] r);
    logic [7:0] rx;
    rx = r ^ `RED;
    return r[0] ? {1'b1, rx[7:1]} : {1'b0, r[7:1]};
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      acc = acc ^ (aa & {8{b[i]}});
      aa  = xtime(aa);
    end
    return acc;
  endfunction

  // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  // Masked inverse S-box: the share is blinded with a 7-bit noise lane
  // (expanded to 8 bits with its parity) and unblinded just before the
  // GF inverse, so the function result is independent of the noise.
  function automatic logic [7:0] masked_inv_sbox(input logic [7:0] x, input logic [6:0] n);
    logic [7:0] m;
    logic [7:0] share;
    m     = {n, ^n};
    share = x ^ m;
    return gf_inv(inv_affine(share ^ m));
  endfunction

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // One forward key-expansion step rk_i -> rk_{i+1}.
  function automatic logic [127:0] key_fwd_step(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w0 = rk[127:96] ^ sub_rot_word(rk[31:0]) ^ {rcon, 24'h000000};
    w1 = rk[95:64] ^ w0;
    w2 = rk[63:32] ^ w1;
    w3 = rk[31:0]  ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // One inverse key step rk_{i+1} -> rk_i, rcon being the one that built rk_{i+1}.
  function automatic logic [127:0] key_inv_step(input logic [127:0] rk, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3;
    w3 = rk[31:0]  ^ rk[63:32];
    w2 = rk[63:32] ^ rk[95:64];
    w1 = rk[95:64] ^ rk[127:96];
    w0 = rk[127:96] ^ sub_rot_word(w3) ^ {rcon, 24'h000000};
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes128_dec_iter_inv_round.sv
// Combinational inverse AES round: InvShiftRows, 16 masked inverse S-boxes,
// AddRoundKey with the backward-derived round key, bypassable InvMixColumns.
module inv_round_128d
  import aes128_dec_iter_pkg::*;
(
  input  logic [127:0]      state_i,
  input  logic [127:0]      rk_i,
  input  logic [7:0]        rcon_i,
  input  logic              last_i,
  input  logic [7*`L-1:0]   noise_i,
  output logic [127:0]      t_o,
  output logic [127:0]      next_o,
  output logic [127:0]      rk_o
);

  logic [127:0] rk_prev_s;
  logic [127:0] sr_s;
  logic [127:0] t_s;
  logic [127:0] mix_s;

  // Round key for this round, stepped back from the previous round's key.
  always_comb begin
    rk_prev_s = key_inv_step(rk_i, rcon_i);
  end

  // InvShiftRows, masked InvSubBytes (one 7-bit noise lane per byte), AddRoundKey.
  always_comb begin
    sr_s = 128'h0;
    t_s  = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        int src;
        int dst;
        src = 4 * ((c + 4 - r) % 4) + r;
        dst = 4 * c + r;
        sr_s[127 - 8*dst -: 8] = state_i[127 - 8*src -: 8];
        t_s[127 - 8*dst -: 8]  = masked_inv_sbox(sr_s[127 - 8*dst -: 8], noise_i[7*dst +: 7])
                                 ^ rk_prev_s[127 - 8*dst -: 8];
      end
    end
  end

  // InvMixColumns, skipped on the final round.
  always_comb begin
    mix_s = 128'h0;
    for (int c = 0; c < 4; c++) begin
      mix_s[127 - 32*c -: 32] = inv_mix_col(t_s[127 - 32*c -: 32]);
    end
    next_o = last_i ? t_s : mix_s;
  end

  assign t_o  = t_s;
  assign rk_o = rk_prev_s;

endmodule

// File: rtl/aes128_dec_iter.sv
// Iterative AES-128 decryption core: one inverse round per clock, round keys
// derived backwards from a cached rk10, key consistency alarm at end of run.
module aes128_dec_iter
  import aes128_dec_iter_pkg::*;
#(
  parameter int NROUNDS      = 10,   // AES-128 only: must be 10
  parameter bit ALARM_STICKY = 1'b1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              start_i,
  input  logic              new_key_i,
  input  logic [127:0]      key_i,
  input  logic [127:0]      data_i,
  input  logic [7*`L-1:0]   noise_i,
  output logic [127:0]      data_o,
  output logic              done_o,
  output logic              ready_o,
  output logic              alarm_o
);

  fsm_e             fsm_r;
  logic [CNT_W-1:0] cnt_r;
  logic [127:0]     data_r;
  logic [127:0]     state_r;
  logic [127:0]     rk_r;
  logic [7:0]       rcon_r;
  logic [127:0]     k0_r;
  logic [127:0]     rk10_r;
  logic             key_valid_r;

  logic [127:0]     kfwd_s;
  logic [127:0]     t_s;
  logic [127:0]     next_s;
  logic [127:0]     rk_prev_s;
  logic             last_s;

  // Forward expansion step used while rebuilding rk10 after a key change.
  always_comb begin
    kfwd_s = key_fwd_step(rk_r, rcon_r);
    last_s = (cnt_r == {CNT_W{1'b0}});
  end

  inv_round_128d u_round (
    .state_i (state_r),
    .rk_i    (rk_r),
    .rcon_i  (rcon_r),
    .last_i  (last_s),
    .noise_i (noise_i),
    .t_o     (t_s),
    .next_o  (next_s),
    .rk_o    (rk_prev_s)
  );

  // Control FSM with datapath registers, key cache and end-of-run key check.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      fsm_r       <= ST_IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      data_r      <= 128'h0;
      state_r     <= 128'h0;
      rk_r        <= 128'h0;
      rcon_r      <= 8'h00;
      k0_r        <= 128'h0;
      rk10_r      <= 128'h0;
      key_valid_r <= 1'b0;
      data_o      <= 128'h0;
      done_o      <= 1'b0;
      ready_o     <= 1'b1;
      alarm_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (!ALARM_STICKY) begin
        alarm_o <= 1'b0;
      end
      case (fsm_r)
        ST_IDLE: begin
          if (start_i) begin
            data_r  <= data_i;
            ready_o <= 1'b0;
            if (new_key_i || !key_valid_r) begin
              k0_r   <= key_i;
              rk_r   <= key_i;
              rcon_r <= RCON_FIRST;
              cnt_r  <= CNT_W'(1);
              fsm_r  <= ST_KEXP;
            end else begin
              state_r <= data_i ^ rk10_r;
              rk_r    <= rk10_r;
              rcon_r  <= RCON_LAST;
              cnt_r   <= CNT_W'(NROUNDS - 1);
              fsm_r   <= ST_DEC;
            end
          end else begin
            ready_o <= 1'b1;
          end
        end
        ST_KEXP: begin
          rk_r <= kfwd_s;
          if (cnt_r == CNT_W'(NROUNDS)) begin
            rk10_r      <= kfwd_s;
            key_valid_r <= 1'b1;
            state_r     <= data_r ^ kfwd_s;
            rcon_r      <= RCON_LAST;
            cnt_r       <= CNT_W'(NROUNDS - 1);
            fsm_r       <= ST_DEC;
          end else begin
            rcon_r <= xtime(rcon_r);
            cnt_r  <= cnt_r + CNT_W'(1);
          end
        end
        ST_DEC: begin
          state_r <= next_s;
          rk_r    <= rk_prev_s;
          rcon_r  <= rcon_inv(rcon_r);
          if (last_s) begin
            data_o <= t_s;
            fsm_r  <= ST_DONE;
          end else begin
            cnt_r <= cnt_r - CNT_W'(1);
          end
        end
        ST_DONE: begin
          done_o  <= 1'b1;
          ready_o <= 1'b1;
          fsm_r   <= ST_IDLE;
          // Stepping back ten rounds must land on the original key.
          if (rk_r != k0_r) begin
            alarm_o     <= 1'b1;
            key_valid_r <= 1'b0;
          end else begin
            key_valid_r <= key_valid_r;
          end
        end
        default: begin
          fsm_r   <= ST_IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/aes128_dec_iter.md
Name: aes128_dec_iter

Overview:
- Iterative AES-128 decryption core; the inverse counterpart of the team's iterative encryption datapath.
- Computes one inverse round per clock.
- Derives round keys backwards on the fly from a cached last-round key (rk10).
- On a key change, first runs a 10-cycle forward key expansion to find rk10.
- Sits beside the encryption core behind the same start/done/ready handshake; end-of-run key check raises a fault alarm.

Parameters:
- NROUNDS, 10, number of AES rounds (fixed for AES-128; only 10 is legal)
- ALARM_STICKY, 1, 1: alarm_o holds until reset; 0: alarm_o is a one-cycle pulse

Ports:
- clk_i  in  1  clock, active rising edge
- arst_n_i  in  1  asynchronous reset, active low
- start_i  in  1  start strobe; sampled only while ready_o=1
- new_key_i  in  1  with start_i: load key_i and re-derive rk10
- key_i  in  128  cipher key; [127:120] = byte 0
- data_i  in  128  ciphertext; [127:120] = byte 0
- noise_i  in  7*`L  masking noise for the inverse S-boxes; fresh every cycle
- data_o  out  128  plaintext; valid while done_o=1, held afterwards
- done_o  out  1  one-cycle pulse, plaintext valid
- ready_o  out  1  core idle, start_i will be accepted
- alarm_o  out  1  key-schedule consistency fault

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, ready_o=1, done_o=0, alarm_o=0, data_o=0, key_valid=0, all datapath registers cleared.
- FSM states: IDLE, KEXP, DEC, DONE.
- IDLE, start_i=1:
  - Capture data_i.
  - If new_key_i=1 or key_valid=0: capture key_i into k0_reg; rk<=key_i; rcon<=0x01; go KEXP.
  - Otherwise: state<=data_i^rk10_reg; rk<=rk10_reg; rcon<=0x36; go DEC.
  - ready_o drops on the cycle following the accept edge.
- KEXP: 10 cycles, counter 1..10; one forward expansion step per cycle.
  - Rcon is doubled in GF(2^8) each step (0x80 -> 0x1b).
  - At count 10: rk10_reg<=result; key_valid<=1; state<=data^result; rcon<=0x36; go DEC.
- DEC: 10 cycles, round r=9..0, down-counter.
  - Each cycle: t = InvSubBytes(InvShiftRows(state)) ^ rk_r, where rk_r comes from the combinational inverse key step on rk.
  - state<=InvMixColumns(t), or t when r=0.
  - rk<=rk_r; rcon<=rcon halved via the inverse GF doubling (0x1b -> 0x80).
  - After r=0: data_o<=t; go DONE.
- DONE: exactly one cycle; done_o=1; ready_o=1 from the same edge; go IDLE.
  - Compare rk against k0_reg. On mismatch, set alarm_o, and clear key_valid so the next start forces re-expansion.
- Latency, start sample edge to done_o rise:
  - 11 cycles with cached key.
  - 21 cycles with new key (or with key_valid=0).
- start_i while ready_o=0: ignored; no queueing.
- start_i in the DONE cycle: ignored (ready_o rises on the DONE exit edge).
- key_i and new_key_i are sampled only on accept.
- Reset mid-operation: abort immediately. No done_o, cache invalidated; the next start re-expands the key.
- alarm_o with ALARM_STICKY=0: pulse only during the DONE cycle.
- Inverse S-box masking uses the team's masked GF-inverse chain, with noise_i split per S-box exactly as in the encryption stage.

Decomposition:
- Shared package/defines, constants: `L, `RED, RCON_LAST=8'h36, state encodings, round-count width.
- Sub-module inv_round_128d (combinational): InvShiftRows, 16 masked inverse S-boxes, AddRoundKey, bypassable InvMixColumns, inverse key step.
- The FSM, counters, registers, key cache and alarm compare stay in the top level.

Test Plan:
- Key 000102030405060708090a0b0c0d0e0f, new_key_i=1, data 69c4e0d86a7b0430d8cdb78070b4c55a -> done_o at cycle 21, data_o=00112233445566778899aabbccddeeff; internal rk10_reg=13111d7fe3944a17f307a78b4d2b30c5.
- Same key cached, new_key_i=0, same data -> done_o at cycle 11, same plaintext, alarm_o=0.
- Key 2b7e151628aed2a6abf7158809cf4f3c, new_key_i=1, data 3925841d02dc09fbdc118597196a0b32 -> data_o=3243f6a8885a308d313198a2e0370734.
- start_i pulsed at cycles 3 and 8 of a run, with a different data_i -> ignored; result unchanged, single done_o pulse.
- arst_n_i low at DEC round 5, then start with new_key_i=0 -> no done_o from the aborted run; next run takes the 21-cycle path with correct plaintext.
- Force one bit of rk10_reg via the bench, then decrypt -> alarm_o=1 in the DONE cycle; the next start takes the 21-cycle path.
